// File: rtl/vga_plot_sequencer.sv
// vga_plot_sequencer: queues CPU pixel-plot and screen-fill commands and drives
// the VGA adapter plot handshake one pixel at a time. Off-screen pixel commands
// are accepted and discarded, with a one-cycle dropped pulse. Command order is kept.
module vga_plot_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_data,
  input  logic        vga_ready,
  output logic        vga_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        dropped,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE_C = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);
  localparam logic [8:0]    SCR_W_C   = 9'(SCREEN_W);
  localparam logic [7:0]    SCR_H_C   = 8'(SCREEN_H);
  localparam logic [7:0]    X_LAST_C  = 8'(SCREEN_W - 1);
  localparam logic [6:0]    Y_LAST_C  = 7'(SCREEN_H - 1);

  // Sequencer states: draining queued pixels, or sweeping the whole screen.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // Queue storage: each entry is {x[7:0], y[6:0], colour[2:0]}.
  logic [17:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  logic [0:0]    state_r;
  logic          fill_pending_r;
  logic [2:0]    fill_colour_r;
  logic [7:0]    fx_r;
  logic [6:0]    fy_r;

  logic          vga_plot_r;
  logic [7:0]    vga_x_r;
  logic [6:0]    vga_y_r;
  logic [2:0]    vga_colour_r;
  logic          dropped_r;

  logic [7:0]    cmd_x_s;
  logic [6:0]    cmd_y_s;
  logic [2:0]    cmd_colour_s;
  logic          on_screen_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          cmd_ready_s;
  logic          accept_s;
  logic          push_s;
  logic          load_s;
  logic          pop_s;
  logic [17:0]   rd_entry_s;

  // Decode the command word and derive the handshake, push and pop strobes.
  always_comb begin
    cmd_x_s      = cmd_data[23:16];
    cmd_y_s      = cmd_data[30:24];
    cmd_colour_s = cmd_data[2:0];
    on_screen_s  = ({1'b0, cmd_x_s} < SCR_W_C) && ({1'b0, cmd_y_s} < SCR_H_C);
    fifo_empty_s = (count_r == {(AW+1){1'b0}});
    fifo_full_s  = (count_r == DEPTH_C);
    // A pending or running fill blocks new commands so fill pixels never interleave.
    cmd_ready_s  = !rst && !fifo_full_s && !fill_pending_r && (state_r != ST_FILL);
    accept_s     = cmd_valid && cmd_ready_s;
    push_s       = accept_s && !cmd_op && on_screen_s;
    // The output register is free when empty or when the adapter takes it this edge.
    load_s       = !vga_plot_r || vga_ready;
    pop_s        = (state_r == ST_IDLE) && load_s && !fifo_empty_s;
    rd_entry_s   = fifo_mem_r[rd_ptr_r];
  end

  // Write accepted on-screen pixels into the queue storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {cmd_x_s, cmd_y_s, cmd_colour_s};
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE_C;
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CNT_ONE_C;
      end
    end
  end

  // Off-screen pixel commands raise dropped for the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_r <= 1'b0;
    end else begin
      dropped_r <= accept_s && !cmd_op && !on_screen_s;
    end
  end

  // Sequencer: fill bookkeeping, screen sweep and the pixel output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      fill_pending_r <= 1'b0;
      fill_colour_r  <= 3'd0;
      fx_r           <= 8'd0;
      fy_r           <= 7'd0;
      vga_plot_r     <= 1'b0;
      vga_x_r        <= 8'd0;
      vga_y_r        <= 7'd0;
      vga_colour_r   <= 3'd0;
    end else begin
      if (accept_s && cmd_op) begin
        fill_pending_r <= 1'b1;
        fill_colour_r  <= cmd_colour_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            vga_plot_r   <= 1'b1;
            vga_x_r      <= rd_entry_s[17:10];
            vga_y_r      <= rd_entry_s[9:3];
            vga_colour_r <= rd_entry_s[2:0];
          end else begin
            if (load_s) begin
              vga_plot_r <= 1'b0;
            end
            // The fill starts only once every earlier queued pixel has left the queue.
            if (fifo_empty_s && fill_pending_r) begin
              state_r <= ST_FILL;
              fx_r    <= 8'd0;
              fy_r    <= 7'd0;
            end
          end
        end
        ST_FILL: begin
          if (load_s) begin
            vga_plot_r   <= 1'b1;
            vga_x_r      <= fx_r;
            vga_y_r      <= fy_r;
            vga_colour_r <= fill_colour_r;
            if (fx_r == X_LAST_C) begin
              fx_r <= 8'd0;
              if (fy_r == Y_LAST_C) begin
                fy_r           <= 7'd0;
                fill_pending_r <= 1'b0;
                state_r        <= ST_IDLE;
              end else begin
                fy_r <= fy_r + 7'd1;
              end
            end else begin
              fx_r <= fx_r + 8'd1;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          vga_plot_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_s;
  assign vga_plot   = vga_plot_r;
  assign vga_x      = vga_x_r;
  assign vga_y      = vga_y_r;
  assign vga_colour = vga_colour_r;
  assign dropped    = dropped_r;
  assign busy       = !fifo_empty_s || fill_pending_r || (state_r == ST_FILL) || vga_plot_r;

endmodule
